jam_cost_server: RTL and testbench

//  Responder end of the JAM cost-request interface. Holds an 8x8 worker/job cost table and returns

---
 rtl/jam_cost_server.sv | 101 ++++++++++
 tb/tb_jam_cost_server.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/jam_cost_server.sv
// rtl/jam_cost_server.sv - JAM cost-request responder: 8x8 cost table, result check, timeout
module jam_cost_server #(
  parameter int              TO_W    = 20,
  parameter logic [TO_W-1:0] TIMEOUT = 20'hFFFFF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       load_en,
  input  logic [5:0] load_addr,
  input  logic [6:0] load_data,
  input  logic [9:0] exp_min,
  input  logic [3:0] exp_cnt,
  input  logic       start,
  input  logic [2:0] W,
  input  logic [2:0] J,
  output logic [6:0] Cost,
  input  logic       Valid,
  input  logic [9:0] MinCost,
  input  logic [3:0] MatchCount,
  output logic       eng_rst,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       timeout,
  output logic [9:0] got_min,
  output logic [3:0] got_cnt
);

  typedef enum logic [1:0] {IDLE, SERVE, DONE} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TIMEOUT - {{(TO_W-1){1'b0}}, 1'b1};

  state_t          state;
  logic [6:0]      cost_tab [64];
  logic [6:0]      cost_q;
  logic [TO_W-1:0] to_cnt;
  logic [9:0]      exp_min_q;
  logic [3:0]      exp_cnt_q;

  // The table survives RST so a rerun after an abort needs no reload.
  always_ff @(posedge CLK) begin
    if (load_en && state == IDLE)
      cost_tab[load_addr] <= load_data;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cost_q    <= 7'd0;
      to_cnt    <= '0;
      exp_min_q <= 10'd0;
      exp_cnt_q <= 4'd0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      got_min   <= 10'd0;
      got_cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          cost_q <= 7'd0;
          if (start) begin
            state     <= SERVE;
            exp_min_q <= exp_min;
            exp_cnt_q <= exp_cnt;
            to_cnt    <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
          end
        end
        SERVE: begin
          cost_q <= cost_tab[{W, J}];
          to_cnt <= to_cnt + 1'b1;
          // Valid takes priority over a timeout landing on the same edge.
          if (Valid) begin
            state   <= DONE;
            cost_q  <= 7'd0;
            done    <= 1'b1;
            got_min <= MinCost;
            got_cnt <= MatchCount;
            pass    <= (MinCost == exp_min_q) && (MatchCount == exp_cnt_q);
            timeout <= 1'b0;
          end else if (to_cnt == TO_LAST) begin
            state   <= DONE;
            cost_q  <= 7'd0;
            done    <= 1'b1;
            pass    <= 1'b0;
            timeout <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Cost    = cost_q;
  assign busy    = (state == SERVE);
  assign eng_rst = (state != SERVE);

endmodule

// File: tb/tb_jam_cost_server.sv
// tb/tb_jam_cost_server.sv - randomized self-checking bench for jam_cost_server
module tb_jam_cost_server;

  logic       CLK = 1'b0;
  logic       RST;
  logic       load_en;
  logic [5:0] load_addr;
  logic [6:0] load_data;
  logic [9:0] exp_min;
  logic [3:0] exp_cnt;
  logic       start;
  logic [2:0] W, J;
  logic [6:0] Cost;
  logic       Valid;
  logic [9:0] MinCost;
  logic [3:0] MatchCount;
  logic       eng_rst, busy, done, pass, timeout;
  logic [9:0] got_min;
  logic [3:0] got_cnt;

  int nvec = 0;
  int nerr = 0;
  int ref_tab [64];
  logic [9:0] last_min;
  logic [3:0] last_cnt;

  jam_cost_server #(.TO_W(20), .TIMEOUT(20'd16)) dut (
    .CLK(CLK), .RST(RST), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .exp_min(exp_min), .exp_cnt(exp_cnt), .start(start), .W(W), .J(J), .Cost(Cost),
    .Valid(Valid), .MinCost(MinCost), .MatchCount(MatchCount), .eng_rst(eng_rst),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .got_min(got_min),
    .got_cnt(got_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_load(input int a, input int d);
    load_en = 1'b1; load_addr = a[5:0]; load_data = d[6:0];
    tick();
    load_en = 1'b0;
    ref_tab[a] = d;
  endtask

  task automatic do_start(input int emin, input int ecnt);
    exp_min = emin[9:0]; exp_cnt = ecnt[3:0]; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic rand_wj(output int idx);
    idx = $urandom_range(0, 63);
    W = idx[5:3]; J = idx[2:0];
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(); tick();
    nvec++;
    if ({busy, done, pass, timeout, eng_rst} !== 5'b00001) begin
      nerr++; $display("FAIL reset_status: got %b want 00001", {busy, done, pass, timeout, eng_rst});
    end
    nvec++;
    if (Cost !== 7'd0 || got_min !== 10'd0 || got_cnt !== 4'd0) begin
      nerr++; $display("FAIL reset_values: got cost=%0d min=%0d cnt=%0d want 0", Cost, got_min, got_cnt);
    end
    RST = 1'b0;
    tick();
    nvec++;
    if ({busy, done, eng_rst} !== 3'b001) begin
      nerr++; $display("FAIL idle_status: got %b want 001", {busy, done, eng_rst});
    end
  endtask

  task automatic test_cost_lookup();
    int idx;
    for (int a = 0; a < 64; a++) do_load(a, a);
    do_start(100, 2);
    nvec++;
    if ({busy, done, eng_rst} !== 3'b100 || Cost !== 7'd0) begin
      nerr++; $display("FAIL serve_entry: got st=%b cost=%0d want st=100 cost=0", {busy, done, eng_rst}, Cost);
    end
    W = 3'd3; J = 3'd5; tick();
    nvec++;
    if (Cost !== 7'd29) begin nerr++; $display("FAIL cost_3_5: got %0d want 29", Cost); end
    W = 3'd7; J = 3'd7; tick();
    nvec++;
    if (Cost !== 7'd63) begin nerr++; $display("FAIL cost_7_7: got %0d want 63", Cost); end
    for (int i = 0; i < 8; i++) begin
      rand_wj(idx); tick();
      nvec++;
      if (Cost !== ref_tab[idx][6:0]) begin
        nerr++; $display("FAIL cost_rand[%0d]: got %0d want %0d", idx, Cost, ref_tab[idx]);
      end
    end
    Valid = 1'b1; MinCost = 10'd100; MatchCount = 4'd2; tick(); Valid = 1'b0;
    nvec++;
    if ({busy, done, pass, timeout, eng_rst} !== 5'b01101 || Cost !== 7'd0) begin
      nerr++; $display("FAIL result_pass: got st=%b cost=%0d want st=01101 cost=0", {busy, done, pass, timeout, eng_rst}, Cost);
    end
    nvec++;
    if (got_min !== 10'd100 || got_cnt !== 4'd2) begin
      nerr++; $display("FAIL got_pass: got %0d/%0d want 100/2", got_min, got_cnt);
    end
  endtask

  task automatic test_load_ignored();
    load_en = 1'b1; load_addr = 6'd1; load_data = 7'd99; tick(); load_en = 1'b0;
    do_start(100, 2);
    W = 3'd0; J = 3'd0; load_en = 1'b1; load_addr = 6'd0; load_data = 7'd99; tick();
    load_en = 1'b0; tick();
    nvec++;
    if (Cost !== ref_tab[0][6:0]) begin nerr++; $display("FAIL serve_load_ignored: got %0d want %0d", Cost, ref_tab[0]); end
    J = 3'd1; tick();
    nvec++;
    if (Cost !== ref_tab[1][6:0]) begin nerr++; $display("FAIL done_load_ignored: got %0d want %0d", Cost, ref_tab[1]); end
    Valid = 1'b1; MinCost = 10'd100; MatchCount = 4'd3; tick(); Valid = 1'b0;
    nvec++;
    if ({busy, done, pass, timeout} !== 4'b0100 || got_cnt !== 4'd3) begin
      nerr++; $display("FAIL result_mismatch: got st=%b cnt=%0d want st=0100 cnt=3", {busy, done, pass, timeout}, got_cnt);
    end
  endtask

  task automatic test_random_results();
    int idx, emin, ecnt, mc, cnt, kind, k;
    logic want_pass;
    for (int n = 0; n < 10; n++) begin
      emin = $urandom_range(0, 1023); ecnt = $urandom_range(0, 15);
      do_start(emin, ecnt);
      k = $urandom_range(0, 12);
      for (int i = 0; i < k; i++) begin
        rand_wj(idx); tick();
        nvec++;
        if (Cost !== ref_tab[idx][6:0]) begin
          nerr++; $display("FAIL rand_cost[%0d]: got %0d want %0d", idx, Cost, ref_tab[idx]);
        end
      end
      kind = $urandom_range(0, 2);
      mc = emin; cnt = ecnt;
      if (kind == 1) mc = emin ^ (1 << $urandom_range(0, 9));
      if (kind == 2) cnt = ecnt ^ (1 << $urandom_range(0, 3));
      want_pass = (mc == emin) && (cnt == ecnt);
      Valid = 1'b1; MinCost = mc[9:0]; MatchCount = cnt[3:0]; tick(); Valid = 1'b0;
      nvec++;
      if ({busy, done, pass, timeout} !== {2'b01, want_pass, 1'b0} || Cost !== 7'd0) begin
        nerr++; $display("FAIL rand_result[%0d]: got st=%b cost=%0d want st=01%b0", n, {busy, done, pass, timeout}, Cost, want_pass);
      end
      nvec++;
      if (got_min !== mc[9:0] || got_cnt !== cnt[3:0]) begin
        nerr++; $display("FAIL rand_got[%0d]: got %0d/%0d want %0d/%0d", n, got_min, got_cnt, mc, cnt);
      end
      last_min = mc[9:0]; last_cnt = cnt[3:0];
    end
  endtask

  task automatic test_timeout();
    int idx;
    logic early_done;
    do_start(5, 1);
    early_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      rand_wj(idx); tick();
      if (done !== 1'b0) early_done = 1'b1;
    end
    nvec++;
    if (early_done) begin nerr++; $display("FAIL timeout_early: got done before 16 cycles want none"); end
    tick();
    nvec++;
    if ({busy, done, pass, timeout, eng_rst} !== 5'b01011 || Cost !== 7'd0) begin
      nerr++; $display("FAIL timeout_hit: got st=%b cost=%0d want st=01011 cost=0", {busy, done, pass, timeout, eng_rst}, Cost);
    end
    nvec++;
    if (got_min !== last_min || got_cnt !== last_cnt) begin
      nerr++; $display("FAIL timeout_got_kept: got %0d/%0d want %0d/%0d", got_min, got_cnt, last_min, last_cnt);
    end
    do_start(5, 1);
    for (int i = 0; i < 15; i++) begin rand_wj(idx); tick(); end
    Valid = 1'b1; MinCost = 10'd5; MatchCount = 4'd1; tick(); Valid = 1'b0;
    nvec++;
    if ({busy, done, pass, timeout} !== 4'b0110) begin
      nerr++; $display("FAIL valid_beats_timeout: got %b want 0110", {busy, done, pass, timeout});
    end
  endtask

  task automatic test_rst_mid_serve();
    int a, d;
    do_start(0, 0);
    W = 3'd2; J = 3'd2; tick(); tick();
    RST = 1'b1; tick(); RST = 1'b0;
    nvec++;
    if ({busy, done, pass, timeout, eng_rst} !== 5'b00001 || Cost !== 7'd0 || got_min !== 10'd0 || got_cnt !== 4'd0) begin
      nerr++; $display("FAIL rst_abort: got st=%b cost=%0d got=%0d/%0d want 00001 0 0/0", {busy, done, pass, timeout, eng_rst}, Cost, got_min, got_cnt);
    end
    for (int i = 0; i < 4; i++) do_load($urandom_range(0, 63), $urandom_range(0, 127));
    a = $urandom_range(0, 63); d = $urandom_range(0, 127);
    load_en = 1'b1; load_addr = a[5:0]; load_data = d[6:0];
    exp_min = 10'd7; exp_cnt = 4'd7; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0; ref_tab[a] = d;
    W = a[5:3]; J = a[2:0]; tick();
    nvec++;
    if (Cost !== d[6:0]) begin nerr++; $display("FAIL load_with_start: got %0d want %0d", Cost, d); end
    W = 3'd3; J = 3'd5; tick();
    nvec++;
    if (Cost !== ref_tab[29][6:0]) begin nerr++; $display("FAIL table_retained: got %0d want %0d", Cost, ref_tab[29]); end
    Valid = 1'b1; MinCost = 10'd7; MatchCount = 4'd7; tick(); Valid = 1'b0;
    nvec++;
    if ({busy, done, pass, timeout} !== 4'b0110) begin
      nerr++; $display("FAIL rerun_result: got %b want 0110", {busy, done, pass, timeout});
    end
  endtask

  initial begin
    RST = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0; exp_min = '0; exp_cnt = '0;
    start = 1'b0; W = '0; J = '0; Valid = 1'b0; MinCost = '0; MatchCount = '0;
    last_min = '0; last_cnt = '0;
    for (int i = 0; i < 64; i++) ref_tab[i] = 0;
    test_reset();
    test_cost_lookup();
    test_load_ignored();
    test_random_results();
    test_timeout();
    test_rst_mid_serve();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
